serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that replaces the single-bit combinational full adder as the datapath arithmetic primitive. It processes a WIDTH-bit operation DIGIT bits per clock through an internal carry-chain slice. A start/busy/done handshake sequences each operation, and results are held until the next operation. It targets area-constrained paths where a WIDTH-bit ripple chain is too large and latency is acceptable.

---
 rtl/serial_adder_if.sv | 16 +
 rtl/serial_adder.sv | 82 ++++++++
 tb/tb_serial_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus for serial_adder
// master drives start, a, b, c_in, sub; slave returns busy, done, sum, carry_out, overflow
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  modport master (output start, a, b, c_in, sub, input busy, done, sum, carry_out, overflow);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, carry_out, overflow);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/sub processing WIDTH bits DIGIT bits per clock
// clk: rising-edge clock; rst_n: async active-low reset
// bus (slave): start/a/b/c_in/sub in, busy/done/sum/carry_out/overflow out
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             co_q, co_d, ov_q, ov_d, busy_q, busy_d, done_q, done_d;
  logic             run, last, accept;
  logic [WIDTH-1:0] b_eff, res_shift;
  logic [DIGIT:0]   slice;
  always_comb begin
    run       = state_q == RUN;
    last      = run && cnt_q == CW'(N - 1);
    accept    = state_q != RUN && bus.start;
    b_eff     = bus.sub ? ~bus.b : bus.b;
    slice     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // partial sum enters at the top so the LSB digit ends up at bit 0 after N shifts
    res_shift = WIDTH'({slice[DIGIT-1:0], res_q} >> DIGIT);
    state_d   = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    a_d       = accept ? bus.a : run ? a_q >> DIGIT : a_q;
    b_d       = accept ? b_eff : run ? b_q >> DIGIT : b_q;
    // subtraction is a + ~b + ~c_in, so the borrow-in enters inverted
    carry_d   = accept ? bus.c_in ^ bus.sub : run ? slice[DIGIT] : carry_q;
    cnt_d     = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    res_d     = run ? res_shift : res_q;
    a_msb_d   = accept ? bus.a[WIDTH-1] : a_msb_q;
    b_msb_d   = accept ? b_eff[WIDTH-1] : b_msb_q;
    sum_d     = last ? res_shift : sum_q;
    co_d      = last ? slice[DIGIT] : co_q;
    ov_d      = last ? (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q) : ov_q;
    busy_d    = state_d == RUN;
    done_d    = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and randomized checks of serial_adder at DIGIT=1 and DIGIT=4
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, cin = 1'b0, sb = 1'b0, sel = 1'b0;
  logic [7:0] a = '0, b = '0;
  int         pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();
  assign bus1.start = start & ~sel;
  assign bus4.start = start & sel;
  assign bus1.a = a;
  assign bus4.a = a;
  assign bus1.b = b;
  assign bus4.b = b;
  assign bus1.c_in = cin;
  assign bus4.c_in = cin;
  assign bus1.sub = sb;
  assign bus4.sub = sb;
  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  wire       busy_s = sel ? bus4.busy : bus1.busy;
  wire       done_s = sel ? bus4.done : bus1.done;
  wire [7:0] sum_s  = sel ? bus4.sum : bus1.sum;
  wire       co_s   = sel ? bus4.carry_out : bus1.carry_out;
  wire       ov_s   = sel ? bus4.overflow : bus1.overflow;
  typedef struct {
    logic       sel;
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum;
    logic       co, ov;
  } vec_t;
  vec_t vecs [5];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  function automatic void model(input logic [7:0] x, y, input logic c, s,
                                output logic [7:0] r, output logic co, ov);
    int u, sv;
    u  = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
    sv = s ? int'($signed(x)) - int'($signed(y)) - int'(c) : int'($signed(x)) + int'($signed(y)) + int'(c);
    r  = u[7:0];
    co = s ? u >= 0 : u > 255;
    ov = sv < -128 || sv > 127;
  endfunction
  task automatic launch(input logic s, input logic [7:0] x, y, input logic c, su);
    sel = s; a = x; b = y; cin = c; sb = su; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy_s, 1);
    check("done_after_accept", done_s, 0);
  endtask
  task automatic finish_op(input string nm, input logic [7:0] es, input logic eco, eov, input bit hold);
    int k = 0;
    logic [7:0] prev = sum_s;
    for (int i = 1; i <= 20; i++) begin
      if (hold) begin
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      end
      @(negedge clk);
      if (done_s) begin
        k = i;
        break;
      end
      check({nm, "_stable"}, sum_s, prev);
    end
    start = 1'b0;
    check({nm, "_latency"}, k, sel ? 2 : 8);
    check({nm, "_busy_at_done"}, busy_s, 0);
    check({nm, "_sum"}, sum_s, es);
    check({nm, "_carry"}, co_s, eco);
    check({nm, "_ovf"}, ov_s, eov);
  endtask
  task automatic settle(input string nm);
    @(negedge clk);
    check({nm, "_done_pulse"}, done_s, 0);
    check({nm, "_idle_busy"}, busy_s, 0);
  endtask
  initial begin
    logic [7:0] es;
    logic eco, eov;
    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    check("rst_busy", bus1.busy, 0);
    check("rst_done", bus1.done, 0);
    check("rst_sum", bus1.sum, 0);
    check("rst_carry", bus1.carry_out, 0);
    check("rst_ovf", bus1.overflow, 0);
    check("rst_sum4", bus4.sum, 0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      launch(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      finish_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].co, vecs[i].ov, 1'b0);
      settle($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 30; i++) begin
      logic s, c, su;
      logic [7:0] x, y;
      s = 1'($urandom); c = 1'($urandom); su = 1'($urandom);
      x = 8'($urandom); y = 8'($urandom);
      model(x, y, c, su, es, eco, eov);
      launch(s, x, y, c, su);
      finish_op("rand", es, eco, eov, 1'b0);
      settle("rand");
    end
    model(8'h3A, 8'h47, 1'b1, 1'b1, es, eco, eov);
    launch(1'b0, 8'h3A, 8'h47, 1'b1, 1'b1);
    finish_op("hold", es, eco, eov, 1'b1);
    settle("hold");
    model(8'h7F, 8'h01, 1'b0, 1'b0, es, eco, eov);
    launch(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    finish_op("b2b_first", es, eco, eov, 1'b0);
    model(8'h05, 8'h09, 1'b0, 1'b1, es, eco, eov);
    launch(1'b0, 8'h05, 8'h09, 1'b0, 1'b1);
    finish_op("b2b_second", es, eco, eov, 1'b0);
    settle("b2b");
    model(8'hA0, 8'h90, 1'b0, 1'b0, es, eco, eov);
    launch(1'b1, 8'hA0, 8'h90, 1'b0, 1'b0);
    finish_op("b2b4_first", es, eco, eov, 1'b0);
    model(8'h11, 8'h22, 1'b1, 1'b0, es, eco, eov);
    launch(1'b1, 8'h11, 8'h22, 1'b1, 1'b0);
    finish_op("b2b4_second", es, eco, eov, 1'b0);
    settle("b2b4");
    launch(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus1.busy, 0);
    check("midrst_done", bus1.done, 0);
    check("midrst_sum", bus1.sum, 0);
    check("midrst_carry", bus1.carry_out, 0);
    check("midrst_ovf", bus1.overflow, 0);
    check("midrst_sum4", bus4.sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", bus1.done, 0);
    end
    model(8'hE3, 8'h2D, 1'b1, 1'b0, es, eco, eov);
    launch(1'b0, 8'hE3, 8'h2D, 1'b1, 1'b0);
    finish_op("after_rst", es, eco, eov, 1'b0);
    settle("after_rst");
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
